synch_fifo_reader: RTL and testbench
====================================

# synch_fifo_reader

Read-side burst engine for `synch_fifo`. On a start command it pops a programmed number of words from the FIFO read port, handling the FIFO's 1-cycle registered read latency. It presents the words downstream on a valid/ready stream with a last-word marker, and sits between a `synch_fifo` instance and any consumer that needs backpressure.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `BURST_MAX`, 16, largest burst length; `CNT_W = $clog2(BURST_MAX+1)`.
- `TIMEOUT`, 64, stall limit in cycles; used only with `READER_TIMEOUT_EN`.
- `clk`  input  1  single clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `start_i`  input  1  burst request; sampled only in IDLE.
- `burst_len_i`  input  CNT_W  words to read; sampled with `start_i`.
- `busy_o`  output  1  high in every state except IDLE.
- `done_o`  output  1  one-cycle completion pulse.
- `timeout_o`  output  1  one-cycle pulse with `done_o` on abort; constant 0 without the macro.
- `rd_en_o`  output  1  FIFO read strobe, combinational.
- `rdata_i`  input  DATA_WIDTH  FIFO read data; valid the cycle after `rd_en_o`.
- `empty_i`  input  1  FIFO empty flag.
- `m_valid_o`  output  1  output word valid.
- `m_data_o`  output  DATA_WIDTH  output word.
- `m_last_o`  output  1  high with the final word of a burst.
- `m_ready_i`  input  1  downstream accept.

## Operation
- **FSM states:** IDLE, RUN, FLUSH, DONE.
- **IDLE:**
  - `start_i=1` with `burst_len_i>0` latches the length and moves to RUN.
  - `burst_len_i=0` moves directly to DONE.
  - A length greater than BURST_MAX is clamped to BURST_MAX.
  - `start_i` is ignored in every other state.
- **Output buffer:**
  - 3-entry FIFO with occupancy `occ`.
  - One in-flight flag `inf` marks that `rd_en_o` was asserted in the previous cycle.
- **Read issue rule:**
  - `rd_en_o = (state==RUN) && !empty_i && (issued < len) && (occ + inf < 3)`.
  - `rd_en_o` is never high while `empty_i=1`, so the reader never causes an FIFO underflow.
- **Capture:** when `inf=1`, `rdata_i` is written into the buffer at the clock edge.
- **Output handshake:**
  - `m_valid_o = (occ>0)`; `m_data_o` is the buffer head.
  - A transfer occurs on a cycle with `m_valid_o && m_ready_i`.
  - Word order is strictly FIFO order.
- **Last word:** `m_last_o` is high with the head word when `accepted == len-1`.
- **Completion:** RUN moves to DONE on the edge where `accepted` reaches `len`.
- **DONE:** lasts one cycle with `done_o=1`, then returns to IDLE.
- **Counters:**
  - `issued` and `accepted` are CNT_W wide and cleared on entry to RUN.
  - Neither counter can exceed `len`.

## Timing
- **Reset values:** all outputs 0; state IDLE; `occ=0`, `inf=0`, both counters 0.
- **Reset mid-burst:**
  - Buffered data is discarded.
  - A read already in flight is not captured.
  - The FIFO's own pointers are not touched.
- **Start latency:** with `start_i` sampled at edge E0:
  - `rd_en_o` can be high in cycle E0..E1.
  - `rdata_i` is valid in E1..E2.
  - `m_valid_o` is high from E2.
- **Throughput:** with `m_ready_i` held high and the FIFO non-empty, one word per cycle is sustained.
- **Backpressure:** while `m_ready_i=0`, at most 3 words are held (buffer plus in-flight) and issue stops.
- **FIFO runs empty mid-burst:** the reader stalls in RUN with no data loss and resumes once `empty_i=0`.

## Configuration
- **`READER_TIMEOUT_EN` defined:**
  - A stall counter counts consecutive RUN cycles with no output transfer, and clears on any transfer.
  - When it reaches TIMEOUT, issue stops and the FSM enters FLUSH.
  - FLUSH lasts one cycle: it drops any in-flight return and clears the buffer.
  - The FSM then enters DONE, with `done_o=1` and `timeout_o=1`.
- **`READER_TIMEOUT_EN` undefined:** no stall counter, RUN waits indefinitely, and `timeout_o` is constant 0.

## Test plan
- **Reset:** assert `rst` for 2 cycles, with FIFO data present and `start_i=1` during reset. Required: all outputs 0, no `rd_en_o`.
- **Full burst:** FIFO preloaded with 16 words 0x10..0x1F, `burst_len_i=16`, `m_ready_i=1`. Required:
  - `m_valid_o` first high 2 cycles after start.
  - 16 back-to-back transfers of 0x10..0x1F, with `m_last_o` only on 0x1F.
  - Exactly 16 `rd_en_o` cycles; `done_o` pulses the cycle after the last transfer.
- **Backpressure:** 16 words, `m_ready_i` toggling 1,0,1,0. Required:
  - Data in order with no duplicates.
  - `occ+inf` never exceeds 3.
  - `rd_en_o` never asserted while `empty_i=1`.
- **Partial FIFO:** 4 words present, `burst_len_i=8`. Required:
  - 4 words delivered, then `busy_o=1` with `rd_en_o=0`.
  - After 4 more words are pushed, the burst completes with `m_last_o` on word 8.
- **Zero length and ignored start:** `burst_len_i=0`. Required: `done_o` pulses on the cycle after the start edge with no `rd_en_o`. A `start_i` pulse during RUN changes neither `len` nor the counters.
- **Timeout:** empty FIFO, `burst_len_i=4`, TIMEOUT=64.
  - With `READER_TIMEOUT_EN`: `done_o` and `timeout_o` pulse together after 64 stalled cycles plus FLUSH, with no `m_valid_o`.
  - Without the macro: `busy_o` stays 1 and `timeout_o` stays 0.

Source files
------------

// File: rtl/synch_fifo_reader.sv
// synch_fifo_reader: burst reader for synch_fifo feeding a valid/ready stream; `READER_TIMEOUT_EN adds a stall abort.
module synch_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX = 16,
  parameter int TIMEOUT = 64,
  localparam int CNT_W = $clog2(BURST_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      burst_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  empty_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] len, issued, accepted;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [1:0] wp, rp, occ;
  logic inf, xfer, last_acc, stall_hit;
  assign xfer = m_valid_o && m_ready_i;
  assign last_acc = accepted == len - CNT_W'(1);
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign m_valid_o = occ != 2'd0;
  assign m_data_o = m_valid_o ? buf_q[rp] : '0;
  assign m_last_o = m_valid_o && last_acc;
  // Buffer slots plus the in-flight read bound the words owed downstream to 3.
  assign rd_en_o = state == RUN && !empty_i && issued < len && ({1'b0, occ} + {2'b0, inf}) < 3'd3 && !stall_hit;
`ifdef READER_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  logic [ST_W-1:0] stall;
  logic to_flag;
  assign stall_hit = state == RUN && !xfer && stall == ST_W'(TIMEOUT - 1);
  assign timeout_o = state == DONE && to_flag;
  always_ff @(posedge clk) begin
    stall <= (rst || state != RUN || xfer) ? '0 : stall + ST_W'(1);
    to_flag <= !rst && state == FLUSH;
  end
`else
  assign stall_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = start_i ? (burst_len_i == '0 ? DONE : RUN) : IDLE;
      RUN:   state_n = stall_hit ? FLUSH : (xfer && last_acc) ? DONE : RUN;
      FLUSH: state_n = DONE;
      DONE:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      issued <= '0;
      accepted <= '0;
      inf <= 1'b0;
      occ <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= state_n;
      inf <= rd_en_o;
      if (state == IDLE && start_i) begin
        len <= burst_len_i > CNT_W'(BURST_MAX) ? CNT_W'(BURST_MAX) : burst_len_i;
        issued <= '0;
        accepted <= '0;
      end else begin
        if (rd_en_o) issued <= issued + CNT_W'(1);
        if (xfer) accepted <= accepted + CNT_W'(1);
      end
      if (state == FLUSH) begin
        occ <= '0;
        wp <= '0;
        rp <= '0;
      end else begin
        if (inf) begin
          buf_q[wp] <= rdata_i;
          wp <= wp == 2'd2 ? 2'd0 : wp + 2'd1;
        end
        if (xfer) rp <= rp == 2'd2 ? 2'd0 : rp + 2'd1;
        occ <= occ + {1'b0, inf} - {1'b0, xfer};
      end
    end
  end
endmodule

// File: tb/tb_synch_fifo_reader.sv
// tb_synch_fifo_reader: scoreboard bench with a behavioural synch_fifo read port model.
module tb_synch_fifo_reader;
  localparam int DW = 8, BM = 16, TO = 64, CW = $clog2(BM + 1);
  logic clk = 0, rst = 1, start_i = 0, m_ready_i = 1;
  logic [CW-1:0] burst_len_i = '0;
  logic [DW-1:0] rdata_i = '0, m_data_o;
  logic busy_o, done_o, timeout_o, rd_en_o, empty_i, m_valid_o, m_last_o;
  logic [DW-1:0] mem [256];
  int pushes = 0, pops = 0, checks = 0, fails = 0, xfers = 0, rd_cnt = 0, rdy_mode = 0;
  logic [8:0] exp_q [$];
  synch_fifo_reader #(.DATA_WIDTH(DW), .BURST_MAX(BM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .burst_len_i(burst_len_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .rd_en_o(rd_en_o),
    .rdata_i(rdata_i), .empty_i(empty_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .m_ready_i(m_ready_i)
  );
  always #5 clk = ~clk;
  assign empty_i = pushes == pops;
  always @(posedge clk)
    if (rd_en_o) begin
      rdata_i <= mem[pops[7:0]];
      pops <= pops + 1;
    end
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  task automatic push_word(input logic [7:0] d);
    mem[pushes[7:0]] = d;
    pushes++;
  endtask
  task automatic load(input int base, input int n, input int len);
    for (int i = 0; i < n; i++) push_word(8'(base + i));
    for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, 8'(base + i)});
  endtask
  task automatic start_burst(input int len);
    @(posedge clk); #2;
    start_i = 1;
    burst_len_i = CW'(len);
    @(posedge clk); #2;
    start_i = 0;
  endtask
  task automatic wait_done(input string name, input int exp_n, input logic exp_to);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 400);
    chk({name, " done"}, int'(done_o), 1);
    if (exp_n > 0) chk({name, " done cycle"}, n, exp_n);
    chk({name, " timeout"}, int'(timeout_o), int'(exp_to));
    @(negedge clk);
    chk({name, " idle after"}, int'({busy_o, done_o, timeout_o}), 0);
    chk({name, " words left"}, exp_q.size(), 0);
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rd_en_o) begin
          rd_cnt++;
          chk("rd_en while empty", int'(empty_i), 0);
        end
        chk("occ+inf<=3", int'(pops - xfers <= 3), 1);
        if (m_valid_o && m_ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected word: got %0h, required none", m_data_o);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            checks--;
            chk("word {last,data}", int'({m_last_o, m_data_o}), int'(e));
          end
          xfers++;
        end
      end
      forever begin
        @(posedge clk); #1;
        m_ready_i = rdy_mode == 1 ? ~m_ready_i : rdy_mode == 0;
      end
    join_none
    load(8'h10, 16, 16);
    start_i = 1;
    burst_len_i = CW'(16);
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("reset outputs", int'({busy_o, done_o, timeout_o, rd_en_o, m_valid_o, m_last_o, m_data_o}), 0);
    end
    @(posedge clk); #2;
    rst = 0;
    start_i = 0;
    @(negedge clk);
    chk("idle outputs", int'({busy_o, done_o, timeout_o, rd_en_o, m_valid_o, m_last_o, m_data_o}), 0);
    rd_cnt = 0;
    start_burst(16);
    @(negedge clk) chk("valid cycle E0", int'(m_valid_o), 0);
    @(negedge clk) chk("valid cycle E1", int'(m_valid_o), 0);
    @(negedge clk) chk("valid cycle E2", int'(m_valid_o), 1);
    wait_done("full", 16, 0);
    chk("full rd_en count", rd_cnt, 16);
    rdy_mode = 1;
    load(8'h20, 16, 16);
    start_burst(20);
    wait_done("backpressure clamp", -1, 0);
    rdy_mode = 0;
    load(8'h40, 4, 8);
    start_burst(8);
    repeat (12) @(negedge clk);
    chk("partial delivered", 8 - exp_q.size(), 4);
    chk("partial busy", int'(busy_o), 1);
    chk("partial rd_en", int'(rd_en_o), 0);
    @(posedge clk); #2;
    start_i = 1;
    burst_len_i = CW'(3);
    @(posedge clk); #2;
    start_i = 0;
    for (int i = 4; i < 8; i++) push_word(8'(8'h40 + i));
    wait_done("partial", -1, 0);
    rd_cnt = 0;
    start_burst(0);
    wait_done("zero length", 1, 0);
    chk("zero length rd_en count", rd_cnt, 0);
    start_burst(4);
`ifdef READER_TIMEOUT_EN
    wait_done("timeout", 66, 1);
`else
    repeat (100) @(negedge clk);
    chk("stall busy", int'(busy_o), 1);
    chk("stall timeout", int'(timeout_o), 0);
    chk("stall done", int'(done_o), 0);
    @(posedge clk); #2;
    load(8'h60, 4, 4);
    wait_done("stall resume", -1, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
